// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one-outstanding imem requests, applies branch predictions and
// buffers returned 4-wide groups in a 2-entry queue feeding the IF/ID register.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        mis_pred,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  input  logic [3:0]  bp_taken,
  input  logic [15:0] bp_target,
  output logic [63:0] pc_to_dec,
  output logic [63:0] inst_to_dec,
  output logic [63:0] recv_pc_to_dec,
  output logic [3:0]  pred_result_to_dec
);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] req_addr_q;
  logic [15:0] tag_base_q;
  logic [3:0]  tag_pred_q;
  logic [1:0]  count_q, count_d;

  logic [63:0] q_pc_q   [2];
  logic [63:0] q_inst_q [2];
  logic [63:0] q_recv_q [2];
  logic [3:0]  q_pred_q [2];
  logic [63:0] q_pc_d   [2];
  logic [63:0] q_inst_d [2];
  logic [63:0] q_recv_d [2];
  logic [3:0]  q_pred_d [2];

  logic        pop, push, issue;
  logic [1:0]  cnt_after_pop, cnt_after_both;
  logic [3:0]  bp_first;
  logic [63:0] new_pc, new_inst, new_recv;

  assign pop            = ~mis_pred & ~stall & (count_q != 2'd0);
  assign push           = ~mis_pred & (state_q == StWait) & imem_rvalid;
  assign cnt_after_pop  = count_q - {1'b0, pop};
  assign cnt_after_both = cnt_after_pop + {1'b0, push};
  assign issue          = ~mis_pred &
                          (((state_q == StIdle) & (cnt_after_pop <= 2'd1)) |
                           (push & (cnt_after_both <= 2'd1)));

  // Isolate the lowest taken slot; later slots in the group are killed.
  assign bp_first  = bp_taken & (~bp_taken + 4'd1);

  assign imem_req  = issue | (state_q != StIdle);
  assign imem_addr = issue ? fetch_pc_q : req_addr_q;

  always_comb begin
    logic killed;
    killed   = 1'b0;
    new_pc   = '0;
    new_inst = '0;
    new_recv = '0;
    for (int i = 0; i < 4; i++) begin
      new_pc[16*i +: 16]   = tag_base_q + 16'(i);
      new_recv[16*i +: 16] = tag_base_q + 16'(i + 1);
      new_inst[16*i +: 16] = killed ? NOP_INST : imem_rdata[16*i +: 16];
      killed               = killed | tag_pred_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      StIdle: begin
        if (issue) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) state_d = issue ? StWait : StIdle;
        else if (mis_pred) state_d = StDiscard;
      end
      StDiscard: begin
        if (imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (mis_pred) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = (|bp_taken) ? bp_target : fetch_pc_q + 16'd4;
    end
  end

  always_comb begin
    q_pc_d   = q_pc_q;
    q_inst_d = q_inst_q;
    q_recv_d = q_recv_q;
    q_pred_d = q_pred_q;
    count_d  = count_q;
    if (mis_pred) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        q_pc_d[0]   = q_pc_q[1];
        q_inst_d[0] = q_inst_q[1];
        q_recv_d[0] = q_recv_q[1];
        q_pred_d[0] = q_pred_q[1];
      end
      // The free slot is the one just past the surviving entries.
      if (push) begin
        q_pc_d[cnt_after_pop[0]]   = new_pc;
        q_inst_d[cnt_after_pop[0]] = new_inst;
        q_recv_d[cnt_after_pop[0]] = new_recv;
        q_pred_d[cnt_after_pop[0]] = tag_pred_q;
      end
      count_d = cnt_after_both;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      tag_base_q <= RESET_PC;
      tag_pred_q <= 4'd0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (issue) begin
        req_addr_q <= fetch_pc_q;
        tag_base_q <= fetch_pc_q;
        tag_pred_q <= bp_first;
      end
    end
  end

  // Entry payload needs no reset; count_q masks stale contents.
  always_ff @(posedge clk) begin
    q_pc_q   <= q_pc_d;
    q_inst_q <= q_inst_d;
    q_recv_q <= q_recv_d;
    q_pred_q <= q_pred_d;
  end

  always_comb begin
    if (count_q != 2'd0) begin
      pc_to_dec          = q_pc_q[0];
      inst_to_dec        = q_inst_q[0];
      recv_pc_to_dec     = q_recv_q[0];
      pred_result_to_dec = q_pred_q[0];
    end else begin
      pc_to_dec          = '0;
      inst_to_dec        = {4{NOP_INST}};
      recv_pc_to_dec     = '0;
      pred_result_to_dec = 4'd0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based model of the fetch stage plus an imem responder,
// compared against the DUT every cycle, with directed scenarios pinned by literal values.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        mis_pred;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic [3:0]  bp_taken;
  logic [15:0] bp_target;
  logic [63:0] pc_to_dec;
  logic [63:0] inst_to_dec;
  logic [63:0] recv_pc_to_dec;
  logic [3:0]  pred_result_to_dec;

  fetch_unit #(
    .RESET_PC (16'h0000),
    .NOP_INST (NOP)
  ) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall              (stall),
    .mis_pred           (mis_pred),
    .redirect_pc        (redirect_pc),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_rvalid        (imem_rvalid),
    .imem_rdata         (imem_rdata),
    .bp_taken           (bp_taken),
    .bp_target          (bp_target),
    .pc_to_dec          (pc_to_dec),
    .inst_to_dec        (inst_to_dec),
    .recv_pc_to_dec     (recv_pc_to_dec),
    .pred_result_to_dec (pred_result_to_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] inst;
    logic [63:0] recv;
    logic [3:0]  pred;
  } ent_t;

  // Behavioural model: a group queue, an outstanding-request flag and a drop flag.
  ent_t        m_q[$];
  bit          m_out, m_disc;
  logic [15:0] m_pc, m_reqaddr, m_tbase;
  int          m_tk;
  logic [15:0] iss_log[$];
  bit          last_issue;

  // Memory responder.
  bit          r_busy, r_stray;
  int          r_cnt;
  logic [15:0] r_addr;
  logic [63:0] cur_rdata;

  // Stimulus for the next cycle.
  logic        s_rst, s_stall, s_mp;
  logic [15:0] s_rpc, s_tgt;
  logic [3:0]  s_bpt;
  int          s_lat;

  int vecs, errs, ncmp;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  function automatic int first_set(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return -1;
  endfunction

  function automatic ent_t mk_entry(input logic [63:0] rd);
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      e.pc[16*i +: 16]   = m_tbase + 16'(i);
      e.recv[16*i +: 16] = m_tbase + 16'(i + 1);
      e.inst[16*i +: 16] = (m_tk >= 0 && i > m_tk) ? NOP : rd[16*i +: 16];
      e.pred[i]          = (i == m_tk);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_cycle();
    bit   rv, pop, push, issue, keep;
    int   sz;
    ent_t h;
    @(negedge clk);
    rv = (r_busy && r_cnt == 0) || r_stray;
    for (int i = 0; i < 4; i++)
      cur_rdata[16*i +: 16] = r_stray ? 16'($urandom) : mem_word(r_addr + 16'(i));
    rst_n       = s_rst;
    stall       = s_stall;
    mis_pred    = s_mp;
    redirect_pc = s_rpc;
    bp_taken    = s_bpt;
    bp_target   = s_tgt;
    imem_rvalid = rv;
    imem_rdata  = cur_rdata;
    #1;
    vecs++;
    if (!s_rst) begin
      m_q.delete();
      m_out      = 0;
      m_disc     = 0;
      m_pc       = 16'h0000;
      r_stray    = r_busy;
      r_busy     = 0;
      last_issue = 0;
    end else begin
      r_stray = 0;
      sz    = m_q.size();
      pop   = !s_mp && !s_stall && sz > 0;
      keep  = m_out && !m_disc && rv;
      push  = !s_mp && keep;
      issue = !s_mp && ((!m_out && sz - int'(pop) <= 1) ||
                        (push && sz - int'(pop) + 1 <= 1));
      if (sz > 0) h = m_q[0];
      else begin
        h.pc = '0; h.inst = {4{NOP}}; h.recv = '0; h.pred = '0;
      end
      chk("imem_req", imem_req, m_out || issue);
      if (m_out || issue) chk("imem_addr", imem_addr, issue ? m_pc : m_reqaddr);
      chk("pc_to_dec", pc_to_dec, h.pc);
      chk("inst_to_dec", inst_to_dec, h.inst);
      chk("recv_pc_to_dec", recv_pc_to_dec, h.recv);
      chk("pred_result", pred_result_to_dec, h.pred);
      if (s_mp) begin
        m_q.delete();
        if (m_out && rv) begin m_out = 0; m_disc = 0; end
        else if (m_out) m_disc = 1;
        m_pc = s_rpc;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(mk_entry(cur_rdata));
        if (m_out && rv) begin m_out = 0; m_disc = 0; end
        if (issue) begin
          m_out     = 1;
          m_disc    = 0;
          m_reqaddr = m_pc;
          m_tbase   = m_pc;
          m_tk      = first_set(s_bpt);
          m_pc      = (m_tk >= 0) ? s_tgt : m_pc + 16'd4;
          iss_log.push_back(m_reqaddr);
        end
      end
      if (rv && r_busy && r_cnt == 0) r_busy = 0;
      else if (r_busy) r_cnt--;
      if (issue) begin
        r_busy = 1;
        r_cnt  = s_lat - 1;
        r_addr = m_reqaddr;
      end
      last_issue = issue;
    end
    @(posedge clk);
  endtask

  // Index of the last logged issue of addr that has a successor, or -1.
  function automatic int find_issue(input logic [15:0] addr);
    for (int i = iss_log.size() - 2; i >= 0; i--) if (iss_log[i] == addr) return i;
    return -1;
  endfunction

  initial begin
    logic [63:0] hold;
    bit          found;
    int          n0, idx;
    vecs = 0; errs = 0; ncmp = 0;
    m_out = 0; m_disc = 0; m_pc = '0; m_reqaddr = '0; m_tbase = '0; m_tk = -1;
    r_busy = 0; r_stray = 0; r_cnt = 0; r_addr = '0; last_issue = 0;
    s_rst = 0; s_stall = 0; s_mp = 0; s_rpc = '0; s_tgt = '0; s_bpt = '0; s_lat = 1;
    rst_n = 0; stall = 0; mis_pred = 0; redirect_pc = '0; imem_rvalid = 0;
    imem_rdata = '0; bp_taken = '0; bp_target = '0;

    repeat (2) do_cycle();
    #1;
    chk("reset_pc", pc_to_dec, 64'h0);
    chk("reset_inst", inst_to_dec, {4{NOP}});
    chk("reset_recv", recv_pc_to_dec, 64'h0);
    chk("reset_pred", pred_result_to_dec, 4'h0);
    s_rst = 1;

    // Stream, latency 1.
    do_cycle(); do_cycle(); #1;
    chk("stream_pc", pc_to_dec, 64'h0003_0002_0001_0000);
    chk("stream_recv", recv_pc_to_dec, 64'h0004_0003_0002_0001);
    do_cycle();
    chk("stream_nissue", iss_log.size(), 3);
    if (iss_log.size() >= 3) begin
      chk("stream_addr0", iss_log[0], 16'h0000);
      chk("stream_addr1", iss_log[1], 16'h0004);
      chk("stream_addr2", iss_log[2], 16'h0008);
    end

    // Predicted taken at 0x0010.
    found = 0;
    s_tgt = 16'h0040;
    for (int n = 0; n < 12 && !found; n++) begin
      s_bpt = (m_pc == 16'h0010) ? 4'b0110 : 4'b0000;
      do_cycle();
      if (m_q.size() > 0 && m_q[0].pc[15:0] == 16'h0010) found = 1;
    end
    s_bpt = 4'b0000;
    #1;
    chk("pred_reached", found, 1'b1);
    chk("pred_result_lit", pred_result_to_dec, 4'b0010);
    chk("pred_inst_killed", inst_to_dec[63:32], {NOP, NOP});
    chk("pred_inst_slot1", inst_to_dec[31:16], mem_word(16'h0011));
    chk("pred_recv1", recv_pc_to_dec[31:16], 16'h0012);
    idx = find_issue(16'h0010);
    chk("pred_found_issue", idx >= 0, 1'b1);
    if (idx >= 0) chk("pred_next_addr", iss_log[idx + 1], 16'h0040);

    // Stall for 5 cycles.
    s_stall = 1;
    do_cycle(); #1;
    hold = pc_to_dec;
    repeat (4) do_cycle();
    #1;
    chk("stall_qfull", m_q.size(), 2);
    chk("stall_hold", pc_to_dec, hold);
    chk("stall_req_low", imem_req, 1'b0);
    s_stall = 0;
    repeat (6) do_cycle();

    // Redirect while a latency-3 request is in flight.
    s_lat = 3;
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      do_cycle();
      if (last_issue) found = 1;
    end
    chk("redir_issued", found, 1'b1);
    s_mp = 1; s_rpc = 16'h0100;
    do_cycle();
    s_mp = 0;
    #1;
    chk("redir_flush_inst", inst_to_dec, {4{NOP}});
    chk("redir_flush_pc", pc_to_dec, 64'h0);
    n0 = iss_log.size();
    repeat (3) do_cycle();
    chk("redir_nissue", iss_log.size(), n0 + 1);
    if (iss_log.size() > n0) chk("redir_addr", iss_log[n0], 16'h0100);
    s_lat = 1;

    // Redirect with a full stalled queue.
    s_stall = 1;
    repeat (5) do_cycle();
    s_mp = 1; s_rpc = 16'h0200;
    do_cycle();
    s_mp = 0; s_stall = 0;
    #1;
    chk("full_flush_pc", pc_to_dec, 64'h0);
    chk("full_flush_pred", pred_result_to_dec, 4'h0);

    // Redirect in the same cycle as the response.
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (r_busy && r_cnt == 0 && m_out && !m_disc) found = 1;
      else do_cycle();
    end
    chk("coll_ready", found, 1'b1);
    s_mp = 1; s_rpc = 16'h0100;
    do_cycle();
    s_mp = 0;
    n0 = iss_log.size();
    do_cycle();
    #1;
    chk("coll_nissue", iss_log.size(), n0 + 1);
    if (iss_log.size() > n0) chk("coll_addr", iss_log[n0], 16'h0100);
    chk("coll_empty", pc_to_dec, 64'h0);

    // PC wrap.
    s_mp = 1; s_rpc = 16'hFFFE;
    do_cycle();
    s_mp = 0;
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      do_cycle();
      if (m_q.size() > 0 && m_q[0].pc[15:0] == 16'hFFFE) found = 1;
    end
    #1;
    chk("wrap_reached", found, 1'b1);
    chk("wrap_pc", pc_to_dec, 64'h0001_0000_FFFF_FFFE);
    idx = find_issue(16'hFFFE);
    chk("wrap_found_issue", idx >= 0, 1'b1);
    if (idx >= 0) chk("wrap_next_addr", iss_log[idx + 1], 16'h0002);

    // Reset mid-request; the stray response that follows must be ignored.
    s_lat = 3;
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      do_cycle();
      if (last_issue) found = 1;
    end
    s_rst = 0;
    do_cycle();
    s_rst = 1;
    repeat (4) do_cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s_rst   = ($urandom_range(0, 199) != 0);
      s_stall = ($urandom_range(0, 9) < 3);
      s_mp    = ($urandom_range(0, 19) == 0);
      s_rpc   = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                            : 16'($urandom);
      s_bpt   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      s_tgt   = 16'($urandom);
      s_lat   = $urandom_range(1, 3);
      do_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Produces the 4-wide fetch groups that the IF/ID pipeline register captures: pc_to_dec, inst_to_dec, recv_pc_to_dec and pred_result_to_dec.
- Generates the fetch PC and talks to the instruction memory through a one-outstanding request/response handshake.
- Applies branch-predictor results: kills slots after the first predicted-taken slot and redirects the PC to the predicted target.
- Buffers returned groups in a 2-entry queue, so decode stalls cause no loss. A mispredict redirect flushes the queue and drops any in-flight response.

Parameters:
- RESET_PC, 16'h0000, fetch PC loaded at reset.
- NOP_INST, 16'h0000, encoding driven into killed or empty instruction slots.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- stall  in  1  decode stall; queue head is not consumed this cycle.
- mis_pred  in  1  mispredict redirect request.
- redirect_pc  in  16  new fetch PC; valid when mis_pred=1.
- imem_req  out  1  request valid; held until imem_rvalid.
- imem_addr  out  16  word address of slot 0; held stable while imem_req=1.
- imem_rvalid  in  1  response valid; only asserted while a request is outstanding.
- imem_rdata  in  64  four consecutive 16-bit words; word at imem_addr+i is in [16i+15:16i].
- bp_taken  in  4  per-slot taken prediction for the group at imem_addr. Combinational lookup, sampled in the cycle imem_req is issued.
- bp_target  in  16  predicted target of the first taken slot; sampled with bp_taken.
- pc_to_dec  out  64  slot i PC in [16i+15:16i].
- inst_to_dec  out  64  slot i instruction in [16i+15:16i].
- recv_pc_to_dec  out  64  slot i recovery PC in [16i+15:16i].
- pred_result_to_dec  out  4  bit i = slot i predicted taken.

Behaviour:
- Reset (rst_n=0 at posedge):
  - fetch_pc=RESET_PC, state=IDLE, queue empty.
  - imem_req=0; pc/recv_pc outputs 0, inst all NOP_INST, pred_result 0.
  - Reset mid-request abandons the request; a later stray imem_rvalid is ignored while in IDLE.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its data is kept.
  - DISCARD: request outstanding; its data is dropped.
- Issue rule: imem_req=1, imem_addr=fetch_pc is asserted combinationally when either:
  - state=IDLE and (queue count after this cycle's pop) <= 1; or
  - state=WAIT and imem_rvalid=1 and (count after pop and push) <= 1 (back-to-back issue).
- At issue, latch the group tag:
  - base=fetch_pc; k = lowest set bit of bp_taken.
  - If any bit set: pred_result=one-hot(k), slots j>k are marked killed, fetch_pc<=bp_target.
  - If no bit set: pred_result=0, fetch_pc<=fetch_pc+4.
  - PC arithmetic is modulo 2^16 (wrap).
- Transitions:
  - IDLE->WAIT on issue.
  - WAIT: on imem_rvalid, push the entry, then go to WAIT if re-issuing, else IDLE.
  - DISCARD->IDLE on imem_rvalid; data dropped, no push.
- Queue entry content: pc_i=base+i; inst_i = killed ? NOP_INST : rdata word i; recv_pc_i=base+i+1 for every slot; pred_result from the tag.
  - recv_pc is meaningful only where pred_result[i]=1.
- Queue is 2 entries, in order. Pop when stall=0 and count>0. Push and pop in the same cycle are allowed. Overflow is impossible by the issue rule.
- Outputs:
  - When count>0, outputs are the head-entry registers.
  - When empty: inst=all NOP_INST, pc/recv_pc=0, pred_result=0.
- mis_pred=1 has priority over stall, issue and push:
  - Queue cleared; fetch_pc<=redirect_pc.
  - No issue that cycle.
  - WAIT->DISCARD, including when imem_rvalid arrives in that same cycle (data dropped, state->IDLE instead).
  - DISCARD stays DISCARD; IDLE stays IDLE.
  - Next issue uses redirect_pc no earlier than the cycle after mis_pred, and only once state=IDLE.
- Back-to-back mis_pred: the last redirect_pc wins.

Test Plan:
- Stream: reset release, rvalid 1 cycle after req, stall=0 -> imem_addr sequence 0x0000, 0x0004, 0x0008. First non-empty output pc_to_dec=64'h0003_0002_0001_0000, recv_pc=64'h0004_0003_0002_0001. One group per cycle after fill.
- Predicted taken: at base 0x0010, bp_taken=4'b0110, bp_target=0x0040 -> pred_result_to_dec=4'b0010, inst slots 2 and 3 = NOP_INST, recv_pc slot1=0x0012, next imem_addr=0x0040.
- Stall: stall=1 for 5 cycles, latency 1 -> queue reaches 2 entries, imem_req drops to 0, outputs stable. After release, groups appear in order with none lost or duplicated.
- Redirect in flight: latency 3, mis_pred at cycle 1 of wait, redirect_pc=0x0100 -> outputs NOP next cycle. Returning data dropped. imem_addr=0x0100 issued the cycle after that rvalid.
- Corner collisions, both:
  - mis_pred with stall=1 and full queue -> queue empty next cycle.
  - mis_pred in the same cycle as imem_rvalid -> that data never reaches outputs; next req 0x0100 the following cycle.
- Wrap: base 0xFFFE, no prediction -> pc_to_dec=64'h0001_0000_FFFF_FFFE, next imem_addr=0x0002.
